// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice plus a registered carry,
// operands consumed LSB-first, parallel sum/c_out presented with a done pulse.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] a_sr_r, a_sr_s;
    logic [WIDTH-1:0] b_sr_r, b_sr_s;
    logic [WIDTH-1:0] acc_r, acc_s;
    logic             carry_r, carry_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic [WIDTH-1:0] sum_r, sum_s;
    logic             c_out_r, c_out_s;
    logic [1:0]       slice_s;

    // One-bit full-adder slice; returns {carry, sum}.
    function automatic logic [1:0] full_adder_dataflow(input logic x, input logic y, input logic ci);
        full_adder_dataflow = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    assign slice_s = full_adder_dataflow(a_sr_r[0], b_sr_r[0], carry_r);

    // Next-state and datapath update; DONE accepts a new start exactly like IDLE.
    always_comb begin
        state_s = state_r;
        a_sr_s  = a_sr_r;
        b_sr_s  = b_sr_r;
        acc_s   = acc_r;
        carry_s = carry_r;
        cnt_s   = cnt_r;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        sum_s   = sum_r;
        c_out_s = c_out_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    a_sr_s  = a;
                    b_sr_s  = b;
                    carry_s = c_in;
                    cnt_s   = '0;
                    busy_s  = 1'b1;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                a_sr_s  = {1'b0, a_sr_r[WIDTH-1:1]};
                b_sr_s  = {1'b0, b_sr_r[WIDTH-1:1]};
                acc_s   = {slice_s[0], acc_r[WIDTH-1:1]};
                carry_s = slice_s[1];
                cnt_s   = cnt_r + CNT_ONE;
                if (cnt_r == CNT_LAST) begin
                    sum_s   = {slice_s[0], acc_r[WIDTH-1:1]};
                    c_out_s = slice_s[1];
                    done_s  = 1'b1;
                    state_s = DONE;
                end else begin
                    busy_s  = 1'b1;
                    state_s = RUN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_sr_r  <= '0;
            b_sr_r  <= '0;
            acc_r   <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sum_r   <= '0;
            c_out_r <= 1'b0;
        end else begin
            state_r <= state_s;
            a_sr_r  <= a_sr_s;
            b_sr_r  <= b_sr_s;
            acc_r   <= acc_s;
            carry_r <= carry_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            sum_r   <= sum_s;
            c_out_r <= c_out_s;
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign sum   = sum_r;
    assign c_out = c_out_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for serial_adder at WIDTH=8.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       c_out;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[8];

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called just after a negedge; launches one addition and waits (bounded) for done.
    task automatic do_add(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                          output int lat, output int busy_cnt);
        a = va; b = vb; c_in = vc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bc;
        int n_done;
        int bad;
        logic [7:0] hold_sum;
        logic       hold_cout;

        checks = 0;
        errors = 0;
        vecs[0] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h3C, 8'hC3, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; c_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_sum", {24'd0, sum}, 32'd0);
        check("reset_cout", {31'd0, c_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_add(vecs[i].a, vecs[i].b, vecs[i].cin, lat, bc);
            check($sformatf("vec%0d_latency", i), lat, 32'd8);
            check($sformatf("vec%0d_busy_cycles", i), bc, 32'd8);
            check($sformatf("vec%0d_busy_in_done", i), {31'd0, busy}, 32'd0);
            check($sformatf("vec%0d_sum", i), {24'd0, sum}, {24'd0, vecs[i].exp_sum});
            check($sformatf("vec%0d_cout", i), {31'd0, c_out}, {31'd0, vecs[i].exp_cout});
            @(negedge clk);
            check($sformatf("vec%0d_done_one_cycle", i), {31'd0, done}, 32'd0);
            check($sformatf("vec%0d_sum_held", i), {24'd0, sum}, {24'd0, vecs[i].exp_sum});
        end

        // Start while busy must be ignored.
        a = 8'h03; b = 8'h04; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 3) begin
                a = 8'h10; b = 8'h10; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                n_done++;
                check("busy_start_sum", {24'd0, sum}, 32'h07);
                check("busy_start_cout", {31'd0, c_out}, 32'd0);
            end
        end
        start = 1'b0;
        check("busy_start_done_count", n_done, 32'd1);
        check("busy_start_sum_final", {24'd0, sum}, 32'h07);

        // Back-to-back: restart during the done cycle.
        do_add(8'h11, 8'h22, 1'b0, lat, bc);
        check("b2b_first_latency", lat, 32'd8);
        check("b2b_first_sum", {24'd0, sum}, 32'h33);
        a = 8'h80; b = 8'h80; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_next", {31'd0, busy}, 32'd1);
        check("b2b_done_low", {31'd0, done}, 32'd0);
        check("b2b_first_sum_held", {24'd0, sum}, 32'h33);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_second_latency", lat, 32'd8);
        check("b2b_second_sum", {24'd0, sum}, 32'h00);
        check("b2b_second_cout", {31'd0, c_out}, 32'd1);
        @(negedge clk);

        // Asynchronous reset in the middle of an addition.
        a = 8'h55; b = 8'hAA; c_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_sum", {24'd0, sum}, 32'd0);
        check("midreset_cout", {31'd0, c_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        check("midreset_no_done", bad, 32'd0);
        do_add(8'h01, 8'h01, 1'b0, lat, bc);
        check("after_reset_latency", lat, 32'd8);
        check("after_reset_sum", {24'd0, sum}, 32'h02);
        check("after_reset_cout", {31'd0, c_out}, 32'd0);

        // Outputs hold while inputs toggle with start low.
        hold_sum = sum;
        hold_cout = c_out;
        @(negedge clk);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
            @(negedge clk);
            if (sum !== 8'h02 || c_out !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("hold_violations", bad, 32'd0);
        check("hold_sum", {24'd0, sum}, {24'd0, hold_sum});
        check("hold_cout", {31'd0, c_out}, {31'd0, hold_cout});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
